// File: rtl/score_ssd_driver.sv
// Score display driver: converts an 8-bit score to BCD with a double-dabble FSM
// and scans the digits onto a 4-digit active-low seven-segment display.
module score_ssd_driver #(
  parameter int SCAN_BITS = 18
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic [7:0]  score,
  output logic [3:0]  An,
  output logic [7:0]  Cath,
  output logic [11:0] bcd,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_r;
  logic [7:0]            last_score_r;
  logic [7:0]            bin_r;
  logic [11:0]           scratch_r;
  logic [11:0]           bcd_r;
  logic [3:0]            iter_r;
  logic [SCAN_BITS+1:0]  scan_r;
  logic [3:0]            an_r;
  logic [7:0]            cath_r;
  logic [1:0]            digit_sel_s;
  logic [19:0]           dd_next_s;
  logic [3:0]            an_next_s;
  logic [7:0]            cath_next_s;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One double-dabble step: {scratch, binary} after nibble correction and shift.
  function automatic logic [19:0] dd_step(input logic [11:0] s, input logic [7:0] b);
    logic [11:0] adj;
    adj = {dd_adj(s[11:8]), dd_adj(s[7:4]), dd_adj(s[3:0])};
    return {adj[10:0], b, 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  assign dd_next_s   = dd_step(scratch_r, bin_r);
  assign digit_sel_s = scan_r[SCAN_BITS+1 -: 2];

  // Next display pattern for the selected slot, with leading-zero blanking.
  always_comb begin
    an_next_s   = 4'b1111;
    cath_next_s = 8'hFF;
    case (digit_sel_s)
      2'd0: begin
        an_next_s   = 4'b1110;
        cath_next_s = {seg7(bcd_r[3:0]), 1'b1};
      end
      2'd1: begin
        if ((bcd_r[11:8] != 4'd0) || (bcd_r[7:4] != 4'd0)) begin
          an_next_s   = 4'b1101;
          cath_next_s = {seg7(bcd_r[7:4]), 1'b1};
        end else begin
          an_next_s   = 4'b1111;
          cath_next_s = 8'hFF;
        end
      end
      2'd2: begin
        if (bcd_r[11:8] != 4'd0) begin
          an_next_s   = 4'b1011;
          cath_next_s = {seg7(bcd_r[11:8]), 1'b1};
        end else begin
          an_next_s   = 4'b1111;
          cath_next_s = 8'hFF;
        end
      end
      default: begin
        an_next_s   = 4'b1111;
        cath_next_s = 8'hFF;
      end
    endcase
  end

  // Conversion FSM: captures a changed score and runs eight shift steps on the copy.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      state_r      <= S_IDLE;
      last_score_r <= 8'd0;
      bin_r        <= 8'd0;
      scratch_r    <= 12'h000;
      iter_r       <= 4'd0;
      bcd_r        <= 12'h000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (score != last_score_r) begin
            bin_r     <= score;
            scratch_r <= 12'h000;
            iter_r    <= 4'd0;
            state_r   <= S_SHIFT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SHIFT: begin
          scratch_r <= dd_next_s[19:8];
          bin_r     <= dd_next_s[7:0];
          iter_r    <= iter_r + 4'd1;
          if (iter_r == 4'd7) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_SHIFT;
          end
        end
        S_DONE: begin
          bcd_r        <= scratch_r;
          // bin_r has shifted out completely, so rebuild the captured value from the result.
          last_score_r <= (scratch_r[11:8] * 8'd100) + (scratch_r[7:4] * 8'd10) + {4'd0, scratch_r[3:0]};
          state_r      <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running scan counter and registered anode/cathode drive.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      scan_r <= '0;
      an_r   <= 4'b1111;
      cath_r <= 8'hFF;
    end else begin
      scan_r <= scan_r + {{(SCAN_BITS+1){1'b0}}, 1'b1};
      an_r   <= an_next_s;
      cath_r <= cath_next_s;
    end
  end

  assign An   = an_r;
  assign Cath = cath_r;
  assign bcd  = bcd_r;
  assign busy = (state_r != S_IDLE);

endmodule

// File: tb/tb_score_ssd_driver.sv
// Scoreboard bench for score_ssd_driver: stimulus pushes expected BCD results,
// a monitor pops and compares them whenever busy falls.
module tb_score_ssd_driver;

  logic        clk;
  logic        Reset;
  logic [7:0]  score;
  logic [3:0]  An;
  logic [7:0]  Cath;
  logic [11:0] bcd;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [11:0] exp_q[$];

  score_ssd_driver #(.SCAN_BITS(2)) dut (
    .ClkPort(clk), .Reset(Reset), .score(score),
    .An(An), .Cath(Cath), .bcd(bcd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset edge; the scan counter equals cyc at every sample point.
  always @(posedge clk) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b0000001;  4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;  4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;  4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;  4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;  4'd9: seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] m_an(input int sel, input logic [11:0] b);
    case (sel)
      0: m_an = 4'b1110;
      1: m_an = ((b[11:8] != 4'd0) || (b[7:4] != 4'd0)) ? 4'b1101 : 4'b1111;
      2: m_an = (b[11:8] != 4'd0) ? 4'b1011 : 4'b1111;
      default: m_an = 4'b1111;
    endcase
  endfunction

  function automatic logic [7:0] m_cath(input int sel, input logic [11:0] b);
    case (sel)
      0: m_cath = {seg(b[3:0]), 1'b1};
      1: m_cath = ((b[11:8] != 4'd0) || (b[7:4] != 4'd0)) ? {seg(b[7:4]), 1'b1} : 8'hFF;
      2: m_cath = (b[11:8] != 4'd0) ? {seg(b[11:8]), 1'b1} : 8'hFF;
      default: m_cath = 8'hFF;
    endcase
  endfunction

  function automatic logic [11:0] dec(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    dec = {h, t, o};
  endfunction

  // Monitor: on every busy fall, check the conversion length and the delivered bcd.
  int   hi_cnt    = 0;
  logic prev_busy = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (Reset) begin
      prev_busy = 1'b0;
      hi_cnt    = 0;
    end else begin
      if (busy) hi_cnt++;
      if (prev_busy && !busy) begin
        check("busy_len", hi_cnt, 9);
        if (exp_q.size() == 0) begin
          check("unexpected_conv", 1, 0);
        end else begin
          check("bcd", {20'd0, bcd}, {20'd0, exp_q.pop_front()});
        end
        hi_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_rise();
    bit seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk); #1;
      if (busy) seen = 1'b1;
    end
    check("busy_rise_timeout", {31'd0, seen}, 1);
  endtask

  task automatic wait_fall();
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (!busy) seen = 1'b1;
    end
    check("busy_fall_timeout", {31'd0, seen}, 1);
  endtask

  task automatic check_display(input logic [11:0] b);
    int sel;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      sel = ((cyc - 1) >> 2) & 3;
      check("an", {28'd0, An}, {28'd0, m_an(sel, b)});
      check("cath", {24'd0, Cath}, {24'd0, m_cath(sel, b)});
      check("busy_idle", {31'd0, busy}, 0);
    end
  endtask

  task automatic check_reset_state();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_bcd", {20'd0, bcd}, 0);
    check("rst_an", {28'd0, An}, 32'hF);
    check("rst_cath", {24'd0, Cath}, 32'hFF);
  endtask

  initial begin
    Reset = 1'b1;
    score = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk) Reset = 1'b0;

    // Score 0 held: no conversion, ones slot shows "0".
    check_display(12'h000);

    @(negedge clk) score = 8'd255;
    exp_q.push_back(12'h255);
    wait_rise(); wait_fall();
    check_display(12'h255);

    @(negedge clk) score = 8'd7;
    exp_q.push_back(12'h007);
    wait_rise(); wait_fall();
    check_display(12'h007);

    // Change during a conversion: first result completes, second starts right after.
    @(negedge clk) score = 8'd100;
    exp_q.push_back(12'h100);
    wait_rise();
    repeat (3) @(posedge clk);
    @(negedge clk) score = 8'd42;
    exp_q.push_back(12'h042);
    wait_fall();
    @(posedge clk); #1;
    check("restart_busy", {31'd0, busy}, 1);
    wait_fall();
    check_display(12'h042);

    // Reset in the 4th shift cycle of a 200 conversion.
    @(negedge clk) score = 8'd200;
    wait_rise();
    repeat (3) @(posedge clk);
    @(negedge clk) Reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state();
    exp_q.push_back(12'h200);
    @(negedge clk) Reset = 1'b0;
    wait_rise(); wait_fall();
    check_display(12'h200);

    // Full sweep, each value held until its conversion finishes.
    for (int v = 0; v < 256; v++) begin
      @(negedge clk) score = 8'(v);
      exp_q.push_back(dec(v));
      wait_rise(); wait_fall();
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_ssd_driver.md
SCORE_SSD_DRIVER -- requirements
Module: score_ssd_driver

Interface
REQ-001 Parameter SCAN_BITS, default 18; each digit slot lasts 2^SCAN_BITS clocks (~2.6 ms at 100 MHz).
REQ-002 ClkPort  in  1  system clock (100 MHz); every register is clocked on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset; one clock; no other clock or async path exists.
REQ-004 score  in  8  unsigned game score from the game state machine; may change on any cycle.
REQ-005 An  out  4  active-low anode enables; An[0] selects the ones digit and An[3] the leftmost digit.
REQ-006 Cath  out  8  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.
REQ-007 bcd  out  12  last converted value: {hundreds,tens,ones}, one nibble each.
REQ-008 busy  out  1  high while a conversion is in progress.

Function
REQ-009 Conversion FSM states: IDLE, SHIFT, DONE.
REQ-010 The conversion works on a captured score register and a 4-bit iteration counter, never on the live score input.
REQ-011 In IDLE, the block compares score with last_score every cycle:
- on mismatch: capture score into an 8-bit binary shift register, clear the 12-bit BCD scratch and the iteration counter, and go to SHIFT;
- otherwise: stay in IDLE.
REQ-012 Each SHIFT cycle runs one double-dabble step:
- add 3 to every scratch nibble that is >=5;
- then shift {scratch, binary} left by 1.
REQ-013 After the 8th SHIFT cycle the FSM goes to DONE.
REQ-014 DONE lasts one cycle: load bcd from the scratch, load last_score with the captured value (not the live input), and return to IDLE.
REQ-015 Latency: if the mismatch is sampled at edge k, bcd updates at edge k+9.
REQ-016 busy = (state != IDLE); it is high for exactly 9 cycles per conversion.
REQ-017 Changes to score while busy are ignored. On return to IDLE a still-different score starts a new conversion immediately; a conversion is never aborted or corrupted.
REQ-018 Scan counter: SCAN_BITS+2 bits, free-running, wraps modulo 2^(SCAN_BITS+2). Digit select = its top 2 bits.
- 0 = ones, 1 = tens, 2 = hundreds, 3 = unused.
REQ-019 An and Cath are registered outputs and lag the digit select by one cycle.
REQ-020 An drives low only the selected slot's bit.
- A blanked slot drives An=4'b1111 and Cath=8'hFF.
REQ-021 Blanking rules:
- hundreds blank when hundreds==0;
- tens blank when hundreds==0 and tens==0;
- ones never blank;
- slot 3 always blank.
REQ-022 Segment codes, abcdefg active-low:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100;
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-023 Dp (Cath[0]) is always 1.
REQ-024 The display always reflects the bcd register, never the scratch, so no intermediate value is ever shown.
REQ-025 bcd is always valid BCD: each nibble is <=9 and hundreds is <=2.

Reset
REQ-026 Reset has priority over all other logic in the same cycle, including a cycle in mid-SHIFT or DONE.
REQ-027 Values after the reset edge:
- FSM = IDLE, busy=0;
- last_score=0, bcd=12'h000;
- scratch, binary and iteration counter = 0;
- scan counter = 0;
- An=4'b1111, Cath=8'hFF.
REQ-028 Only the registered scan path drives the display after reset.
- From the first post-reset edge, the output follows the scan (REQ-018 to REQ-023) of bcd=0x000.
- This shows ones slot "0", i.e. Cath=8'b00000011, when selected.

Verification (SCAN_BITS=2 in simulation)
REQ-029 Reset, score=0 held -> busy never rises; bcd=12'h000; An cycles 1110, 1111, 1111, 1111 every 4 clocks; Cath=8'b00000011 during the ones slot.
REQ-030 score 0->255 -> busy high for 9 cycles; bcd=12'h255 at edge k+9; slots show 5,5,2 with An 1110, 1101, 1011.
REQ-031 score=7 -> bcd=12'h007; tens and hundreds slots blank (An=1111, Cath=8'hFF); ones slot Cath=8'b00011111.
REQ-032 score=100, then 42 during SHIFT -> bcd=12'h100 at the first DONE; a second conversion starts the next cycle; bcd=12'h042 nine cycles later.
REQ-033 Reset at the 4th SHIFT cycle of a 200 conversion -> next edge: busy=0, bcd=12'h000, An=4'b1111; with score still 200, a fresh conversion ends with bcd=12'h200.
REQ-034 Sweep score 0..255, each held until busy falls -> bcd equals the decimal value for all 256 inputs; no nibble ever exceeds 9.
